// File: rtl/ldm_stm_sequencer_if.sv
// rtl/ldm_stm_sequencer_if.sv - memory and register-file access bus of the block-transfer sequencer
interface ldm_stm_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [3:0]  reg_idx;
  logic        reg_wr;
  logic        reg_rd;

  modport master (
    output mem_req, mem_we, mem_addr, reg_idx, reg_wr, reg_rd,
    input  mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, reg_idx, reg_wr, reg_rd,
    output mem_ready
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - LDM/STM block transfer sequencer (IA/IB/DA/DB, optional writeback)
module ldm_stm_sequencer (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                reg_list,
  input  logic [31:0]                base_addr,
  input  logic                       p_bit,
  input  logic                       u_bit,
  input  logic                       w_bit,
  input  logic                       l_bit,
  ldm_stm_sequencer_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       wb_en,
  output logic [31:0]                wb_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_next;

  // Instruction fields captured with start; the live inputs are ignored afterwards
  logic [15:0] list_q;
  logic [31:0] base_q;
  logic        p_q, u_q, w_q, l_q;

  // Transfer datapath
  logic [15:0] mask_q;
  logic [31:0] addr_q;
  logic [3:0]  idx_q;
  logic [31:0] wb_q;
  logic        empty_q;

  logic [4:0]  n_regs;
  logic [31:0] n_bytes;
  logic [31:0] first_addr;
  logic [31:0] final_base;
  logic [15:0] mask_clr;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Scanning downward leaves the lowest set index; an empty mask yields 0
  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Address arithmetic: every mode walks upward, so decrementing modes start below the base
  always_comb begin
    n_regs  = popcount16(list_q);
    n_bytes = {25'd0, n_regs, 2'b00};
    case ({u_q, p_q})
      2'b10:   first_addr = base_q;
      2'b11:   first_addr = base_q + 32'd4;
      2'b00:   first_addr = base_q - n_bytes + 32'd4;
      default: first_addr = base_q - n_bytes;
    endcase
    final_base = u_q ? (base_q + n_bytes) : (base_q - n_bytes);
    mask_clr   = mask_q & (mask_q - 16'd1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and bus outputs
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    wb_en        = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.reg_wr   = 1'b0;
    bus.reg_rd   = 1'b0;
    bus.mem_addr = addr_q;
    bus.reg_idx  = idx_q;
    wb_addr      = wb_q;
    case (state)
      IDLE: begin
        if (start) state_next = SETUP;
      end
      SETUP: begin
        busy       = 1'b1;
        state_next = (n_regs == 5'd0) ? DONE : XFER;
      end
      XFER: begin
        busy        = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_we  = ~l_q;
        bus.reg_rd  = ~l_q;
        bus.reg_wr  = l_q & bus.mem_ready;
        if (bus.mem_ready && mask_clr == 16'd0) state_next = DONE;
      end
      default: begin
        busy       = 1'b1;
        done       = 1'b1;
        wb_en      = w_q & ~empty_q;
        state_next = IDLE;
      end
    endcase
  end

  // Capture on start, compute plan in SETUP, advance one register per completed access
  always_ff @(posedge clk) begin
    if (rst) begin
      list_q  <= '0;
      base_q  <= '0;
      p_q     <= 1'b0;
      u_q     <= 1'b0;
      w_q     <= 1'b0;
      l_q     <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      wb_q    <= '0;
      empty_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            list_q <= reg_list;
            base_q <= base_addr;
            p_q    <= p_bit;
            u_q    <= u_bit;
            w_q    <= w_bit;
            l_q    <= l_bit;
          end
        end
        SETUP: begin
          mask_q  <= list_q;
          addr_q  <= first_addr;
          idx_q   <= lowest_bit(list_q);
          wb_q    <= final_base;
          empty_q <= (n_regs == 5'd0);
        end
        XFER: begin
          if (bus.mem_ready) begin
            mask_q <= mask_clr;
            addr_q <= addr_q + 32'd4;
            idx_q  <= lowest_bit(mask_clr);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - directed self-checking bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        p_bit, u_bit, w_bit, l_bit;
  logic        busy, done, wb_en;
  logic [31:0] wb_addr;
  int          n_checks = 0;
  int          n_errors = 0;

  ldm_stm_sequencer_if bus ();

  ldm_stm_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .p_bit     (p_bit),
    .u_bit     (u_bit),
    .w_bit     (w_bit),
    .l_bit     (l_bit),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic st);
    @(negedge clk);
    bus.mem_ready = rdy;
    start         = st;
    #1;
  endtask

  task automatic do_start(input logic [15:0] list, input logic [31:0] base,
                          input logic p, input logic u, input logic w, input logic l);
    @(negedge clk);
    reg_list      = list;
    base_addr     = base;
    p_bit         = p;
    u_bit         = u;
    w_bit         = w;
    l_bit         = l;
    start         = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
  endtask

  // Whole operation with mem_ready high; idxs holds expected register indices, 4 bits each, first in [3:0]
  task automatic run_op(input string tag, input logic [15:0] list, input logic [31:0] base,
                        input logic p, input logic u, input logic w, input logic l,
                        input int n, input logic [31:0] addr0, input logic [31:0] wb,
                        input logic [63:0] idxs);
    do_start(list, base, p, u, w, l);
    step(1'b1, 1'b0);
    chk({tag, " setup busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " setup mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    for (int i = 0; i < n; i++) begin
      step(1'b1, i == 0);
      chk($sformatf("%s x%0d mem_req", tag, i), {31'd0, bus.mem_req}, 32'd1);
      chk($sformatf("%s x%0d addr", tag, i), bus.mem_addr, addr0 + 32'(4 * i));
      chk($sformatf("%s x%0d idx", tag, i), {28'd0, bus.reg_idx}, {28'd0, idxs[i*4 +: 4]});
      chk($sformatf("%s x%0d we", tag, i), {31'd0, bus.mem_we}, {31'd0, ~l});
      chk($sformatf("%s x%0d reg_wr", tag, i), {31'd0, bus.reg_wr}, {31'd0, l});
      chk($sformatf("%s x%0d reg_rd", tag, i), {31'd0, bus.reg_rd}, {31'd0, ~l});
      chk($sformatf("%s x%0d done", tag, i), {31'd0, done}, 32'd0);
    end
    step(1'b1, 1'b1);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " wb_en"}, {31'd0, wb_en}, {31'd0, w && (n != 0)});
    chk({tag, " wb_addr"}, wb_addr, wb);
    chk({tag, " done mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    step(1'b1, 1'b0);
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " idle done"}, {31'd0, done}, 32'd0);
    chk({tag, " wb_addr held"}, wb_addr, wb);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0;
    p_bit = 1'b0; u_bit = 1'b0; w_bit = 1'b0; l_bit = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst reg_idx", {28'd0, bus.reg_idx}, 32'd0);
    chk("rst wb_addr", wb_addr, 32'd0);
    chk("rst done", {31'd0, done | wb_en | bus.reg_wr | bus.reg_rd | bus.mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("ldmia", 16'h000F, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 4, 32'h0000_1000, 32'h0000_1010, 64'h3210);
    run_op("stmdb", 16'h4010, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b0, 2, 32'h0000_1FF8, 32'h0000_1FF8, 64'hE4);
    run_op("ldmda", 16'h8001, 32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b1, 2, 32'h0000_2FFC, 32'h0000_2FF8, 64'hF0);
    run_op("empty", 16'h0000, 32'h0000_4000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 32'h0, 32'h0000_4000, 64'h0);
    run_op("wrap",  16'h0003, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0, 2, 32'hFFFF_FFFC, 32'h0000_0004, 64'h10);

    // LDMIB with two wait cycles on the second access
    do_start(16'h0006, 32'h0000_1000, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("ldmib setup", {31'd0, bus.mem_req}, 32'd0);
    step(1'b1, 1'b0);
    chk("ldmib x0 addr", bus.mem_addr, 32'h0000_1004);
    chk("ldmib x0 idx", {28'd0, bus.reg_idx}, 32'd1);
    chk("ldmib x0 reg_wr", {31'd0, bus.reg_wr}, 32'd1);
    step(1'b0, 1'b0);
    chk("ldmib w1 addr", bus.mem_addr, 32'h0000_1008);
    chk("ldmib w1 idx", {28'd0, bus.reg_idx}, 32'd2);
    chk("ldmib w1 reg_wr", {31'd0, bus.reg_wr}, 32'd0);
    step(1'b0, 1'b0);
    chk("ldmib w2 addr", bus.mem_addr, 32'h0000_1008);
    chk("ldmib w2 req", {31'd0, bus.mem_req}, 32'd1);
    chk("ldmib w2 reg_wr", {31'd0, bus.reg_wr}, 32'd0);
    step(1'b1, 1'b0);
    chk("ldmib x1 addr", bus.mem_addr, 32'h0000_1008);
    chk("ldmib x1 idx", {28'd0, bus.reg_idx}, 32'd2);
    chk("ldmib x1 reg_wr", {31'd0, bus.reg_wr}, 32'd1);
    step(1'b1, 1'b0);
    chk("ldmib done", {31'd0, done}, 32'd1);
    chk("ldmib wb_en", {31'd0, wb_en}, 32'd1);
    chk("ldmib wb_addr", wb_addr, 32'h0000_1008);

    // Reset during the second transfer of an LDMIA abandons it
    do_start(16'h000F, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("abort x1 idx", {28'd0, bus.reg_idx}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("abort mem_addr", bus.mem_addr, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("abort no done %0d", i), {31'd0, done | busy}, 32'd0);
    end
    run_op("after", 16'h0001, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 1'b1, 1, 32'h0000_0010, 32'h0000_0014, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter: none; address width fixed at 32 bits, word-aligned transfers only.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin a block transfer; sampled only in IDLE.
REQ-005 reg_list  in  16  register list, bit n = Rn (IR[15:0]); sampled with start.
REQ-006 base_addr  in  32  value of Rn; sampled with start.
REQ-007 p_bit, u_bit, w_bit, l_bit  in  1 each  pre-index, up, writeback, load (IR[24], IR[23], IR[21], IR[20]); sampled with start.
REQ-008 mem_ready  in  1  memory completes current access this cycle.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 mem_req  out  1  memory access requested at mem_addr.
REQ-011 mem_we  out  1  1 = store (STM), 0 = load (LDM); valid while mem_req.
REQ-012 mem_addr  out  32  word address of current transfer.
REQ-013 reg_idx  out  4  register index of current transfer.
REQ-014 reg_wr  out  1  load data valid: write bus data into reg_idx this cycle.
REQ-015 reg_rd  out  1  store: drive reg_idx onto write-data path this cycle.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 wb_en  out  1  write wb_addr into base register; high only with done.
REQ-018 wb_addr  out  32  final base value; held from SETUP until next start.

Function
REQ-019 States: IDLE, SETUP, XFER, DONE; 2-bit encoding, IDLE after reset.
REQ-020 IDLE: start=1 latches all inputs and moves to SETUP next edge; start=0 stays.
REQ-021 start while busy is ignored; no queuing.
REQ-022 SETUP (one cycle): N = popcount(reg_list), 0..16, 5 bits.
REQ-023 SETUP start address: IA (U=1,P=0) base; IB (U=1,P=1) base+4; DA (U=0,P=0) base-4N+4; DB (U=0,P=1) base-4N; arithmetic mod 2^32, wraps silently.
REQ-024 SETUP writeback value: U=1 base+4N, U=0 base-4N, mod 2^32.
REQ-025 SETUP with N=0: go to DONE, no memory access, wb_addr=base, wb_en=0.
REQ-026 Registers transfer in ascending index order; lowest index at lowest address; address increments by 4 per transfer for every mode.
REQ-027 XFER: mem_req=1; mem_addr, reg_idx and mem_we held stable until mem_ready=1.
REQ-028 reg_wr = XFER & mem_ready & l_bit; reg_rd = XFER & ~l_bit, throughout the access.
REQ-029 On XFER edge with mem_ready=1: clear the lowest set bit of the remaining mask, mem_addr += 4, reg_idx = next lowest set bit; if the mask is now empty, go to DONE.
REQ-030 XFER with mem_ready=0 holds all state; no reg_wr.
REQ-031 DONE (one cycle): done=1; wb_en=w_bit (0 if N=0); next state IDLE; start in DONE is ignored.
REQ-032 R15 in the list is transferred like any other register; no special PC handling.
REQ-033 With mem_ready tied high, total latency from the start edge to done = N+2 cycles.

Reset
REQ-034 rst overrides all inputs in any state, including mid-XFER: next state IDLE, transfer abandoned, no done.
REQ-035 Reset values: busy, mem_req, mem_we, reg_wr, reg_rd, done, wb_en = 0; mem_addr, wb_addr = 0; reg_idx = 0; remaining mask = 0.

Verification
REQ-036 LDMIA base=0x1000, list=0x000F, W=1, ready=1 -> addresses 0x1000/04/08/0C with idx 0..3 in cycles 2-5; reg_wr each; done+wb_en cycle 6; wb_addr=0x1010.
REQ-037 STMDB base=0x2000, list=0x4010 -> r4@0x1FF8, r14@0x1FFC, mem_we=1, reg_rd=1, no reg_wr; wb_addr=0x1FF8.
REQ-038 LDMDA base=0x3000, list=0x8001 -> r0@0x2FFC, r15@0x3000; wb_addr=0x2FF8.
REQ-039 LDMIB base=0x1000, list=0x0006, ready low for 2 cycles on 2nd access -> 0x1004 (r1), then 0x1008 (r2) held 3 cycles with a single reg_wr; done cycle 6.
REQ-040 Empty list, base=0x4000 -> no mem_req, done in cycle 2 with wb_en=0, wb_addr=0x4000.
REQ-041 rst asserted during 2nd transfer of REQ-036 -> next cycle busy=0, mem_req=0, done never pulses; a new start then runs normally.
